// File: rtl/flag_arb_reg.sv
// flag_arb_reg: N-channel toggle-flag capture register with an arbiter that
// forwards one captured word per cycle to a single registered output, tagged
// with its source channel. Supports round-robin or fixed-priority service and
// sticky per-channel overflow flags.
module flag_arb_reg #(
    parameter int WIDTH = 4,
    parameter int NCH   = 2,
    parameter int RR    = 1,
    parameter int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [NCH-1:0]       f,
    input  logic                 clr_ovf,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid,
    output logic [CW-1:0]        q_ch,
    output logic [NCH-1:0]       ovf
);

    logic [WIDTH-1:0] hold [NCH];
    logic [NCH-1:0]   pend;
    logic [NCH-1:0]   f_d;
    logic             armed;
    logic [CW-1:0]    rr_last;

    logic [NCH-1:0]   ev;
    logic             gnt_found;
    logic [CW-1:0]    gnt_idx;
    logic [NCH-1:0]   gnt_vec;
    logic [NCH-1:0]   ovf_set;
    logic [NCH-1:0]   pend_nx;

    // Search the pending vector starting after the last served channel
    // (round-robin) or from channel 0 (fixed priority); returns {found, index}.
    function automatic logic [CW:0] pick(input logic [NCH-1:0] p,
                                         input logic [CW-1:0]  last);
        logic           found;
        logic [CW-1:0]  idx;
        logic [NCH-1:0] sh;
        int             start;
        int             j;
        found = 1'b0;
        idx   = '0;
        start = (RR != 0) ? ((int'(last) + 1) % NCH) : 0;
        for (int k = 0; k < NCH; k++) begin
            j  = (start + k) % NCH;
            sh = p >> j;
            if (!found && sh[0]) begin
                found = 1'b1;
                idx   = CW'(j);
            end
        end
        return {found, idx};
    endfunction

    // Flag-change detection, grant selection and next-state of pending/overflow.
    always_comb begin
        ev                   = armed ? (f ^ f_d) : '0;
        {gnt_found, gnt_idx} = pick(pend, rr_last);
        gnt_vec              = gnt_found ? (NCH'(1) << gnt_idx) : '0;
        ovf_set              = ev & pend & ~gnt_vec;
        pend_nx              = (pend & ~gnt_vec) | ev;
    end

    // Capture on flag events, forward the granted word, track overflow state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            q       <= '0;
            q_valid <= 1'b0;
            q_ch    <= '0;
            ovf     <= '0;
            pend    <= '0;
            f_d     <= '0;
            armed   <= 1'b0;
            rr_last <= CW'(NCH - 1);
            for (int i = 0; i < NCH; i++) begin
                hold[i] <= '0;
            end
        end else begin
            f_d   <= f;
            armed <= 1'b1;
            pend  <= pend_nx;
            ovf   <= (clr_ovf ? '0 : ovf) | ovf_set;
            for (int i = 0; i < NCH; i++) begin
                if (ev[i]) begin
                    hold[i] <= d[i*WIDTH +: WIDTH];
                end
            end
            if (gnt_found) begin
                q       <= hold[gnt_idx];
                q_ch    <= gnt_idx;
                q_valid <= 1'b1;
                rr_last <= gnt_idx;
            end else begin
                q_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flag_arb_reg.sv
// tb_flag_arb_reg: directed tests for flag_arb_reg with WIDTH=4, NCH=2.
// One round-robin and one fixed-priority instance share all inputs.
module tb_flag_arb_reg;

    logic       clk;
    logic       rstN;
    logic [7:0] d;
    logic [1:0] f;
    logic       clr_ovf;

    logic [3:0] q_rr, q_fp;
    logic       qv_rr, qv_fp;
    logic [0:0] qch_rr, qch_fp;
    logic [1:0] ovf_rr, ovf_fp;

    int total;
    int bad;

    flag_arb_reg #(.WIDTH(4), .NCH(2), .RR(1)) u_rr (
        .clk(clk), .rstN(rstN), .d(d), .f(f), .clr_ovf(clr_ovf),
        .q(q_rr), .q_valid(qv_rr), .q_ch(qch_rr), .ovf(ovf_rr)
    );

    flag_arb_reg #(.WIDTH(4), .NCH(2), .RR(0)) u_fp (
        .clk(clk), .rstN(rstN), .d(d), .f(f), .clr_ovf(clr_ovf),
        .q(q_fp), .q_valid(qv_fp), .q_ch(qch_fp), .ovf(ovf_fp)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset with flags held at fval, release away from an edge, then the arming edge.
    task automatic do_reset(input logic [1:0] fval);
        rstN    = 1'b0;
        f       = fval;
        d       = 8'h00;
        clr_ovf = 1'b0;
        tick;
        tick;
        rstN = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        f    = 2'b11;
        d    = 8'h00;
        clr_ovf = 1'b0;
        #2;
        total++;
        if ({qv_rr, qch_rr, q_rr, ovf_rr} !== 8'h00) begin
            bad++;
            $display("FAIL reset_during got=%h exp=00", {qv_rr, qch_rr, q_rr, ovf_rr});
        end
        do_reset(2'b11);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({qv_rr, qch_rr, q_rr, ovf_rr} !== 8'h00) begin
                bad++;
                $display("FAIL reset_arm_rr cyc=%0d got=%h exp=00", i, {qv_rr, qch_rr, q_rr, ovf_rr});
            end
            total++;
            if ({qv_fp, qch_fp, q_fp, ovf_fp} !== 8'h00) begin
                bad++;
                $display("FAIL reset_arm_fp cyc=%0d got=%h exp=00", i, {qv_fp, qch_fp, q_fp, ovf_fp});
            end
        end
    endtask

    task automatic test_single;
        do_reset(2'b00);
        d = 8'h5A;
        f = 2'b01;
        tick;
        total++;
        if (qv_rr !== 1'b0) begin
            bad++;
            $display("FAIL single_early got qv=%b exp=0", qv_rr);
        end
        tick;
        total++;
        if ({qv_rr, qch_rr, q_rr} !== {1'b1, 1'b0, 4'hA}) begin
            bad++;
            $display("FAIL single_out got v=%b ch=%b q=%h exp v=1 ch=0 q=a", qv_rr, qch_rr, q_rr);
        end
        tick;
        total++;
        if ({qv_rr, qch_rr, q_rr} !== {1'b0, 1'b0, 4'hA}) begin
            bad++;
            $display("FAIL single_after got v=%b ch=%b q=%h exp v=0 ch=0 q=a", qv_rr, qch_rr, q_rr);
        end
    endtask

    task automatic test_simultaneous;
        logic [5:0] exp_rr [6];
        logic [5:0] exp_fp [6];
        do_reset(2'b00);
        d = 8'hC3;
        f = 2'b11;
        tick;
        // First pair, then a repeat pair: ch0 first in both modes.
        exp_rr[0] = {1'b1, 1'b0, 4'h3};
        exp_rr[1] = {1'b1, 1'b1, 4'hC};
        exp_rr[2] = {1'b1, 1'b0, 4'h3};
        exp_rr[3] = {1'b1, 1'b1, 4'hC};
        for (int i = 0; i < 4; i++) begin
            if (i == 1) f = 2'b00;
            tick;
            total++;
            if ({qv_rr, qch_rr, q_rr} !== exp_rr[i]) begin
                bad++;
                $display("FAIL simul_rr step=%0d got=%h exp=%h", i, {qv_rr, qch_rr, q_rr}, exp_rr[i]);
            end
            total++;
            if ({qv_fp, qch_fp, q_fp} !== exp_rr[i]) begin
                bad++;
                $display("FAIL simul_fp step=%0d got=%h exp=%h", i, {qv_fp, qch_fp, q_fp}, exp_rr[i]);
            end
        end
        // Both again, then re-trigger ch0 with 4 on its grant edge: modes diverge.
        f = 2'b11;
        tick;
        d = 8'hC4;
        f = 2'b10;
        exp_rr[0] = {1'b1, 1'b0, 4'h3};
        exp_rr[1] = {1'b1, 1'b1, 4'hC};
        exp_rr[2] = {1'b1, 1'b0, 4'h4};
        exp_fp[0] = {1'b1, 1'b0, 4'h3};
        exp_fp[1] = {1'b1, 1'b0, 4'h4};
        exp_fp[2] = {1'b1, 1'b1, 4'hC};
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({qv_rr, qch_rr, q_rr} !== exp_rr[i]) begin
                bad++;
                $display("FAIL mode_rr step=%0d got=%h exp=%h", i, {qv_rr, qch_rr, q_rr}, exp_rr[i]);
            end
            total++;
            if ({qv_fp, qch_fp, q_fp} !== exp_fp[i]) begin
                bad++;
                $display("FAIL mode_fp step=%0d got=%h exp=%h", i, {qv_fp, qch_fp, q_fp}, exp_fp[i]);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset(2'b00);
        d = {4'h0, 4'h1};
        f = 2'b01;
        tick;
        d = {4'h7, 4'h1};
        f = 2'b10;
        tick;
        f = 2'b11;
        tick;
        total++;
        if ({qv_fp, qch_fp, ovf_fp} !== {1'b1, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL ovf_starve got v=%b ch=%b ovf=%b exp v=1 ch=0 ovf=00", qv_fp, qch_fp, ovf_fp);
        end
        d = {4'h9, 4'h1};
        f = 2'b00;
        tick;
        total++;
        if (ovf_fp !== 2'b10) begin
            bad++;
            $display("FAIL ovf_set got=%b exp=10", ovf_fp);
        end
        tick;
        total++;
        if ({qv_fp, qch_fp, q_fp} !== {1'b1, 1'b0, 4'h1}) begin
            bad++;
            $display("FAIL ovf_last_ch0 got=%h exp=%h", {qv_fp, qch_fp, q_fp}, {1'b1, 1'b0, 4'h1});
        end
        tick;
        total++;
        if ({qv_fp, qch_fp, q_fp, ovf_fp} !== {1'b1, 1'b1, 4'h9, 2'b10}) begin
            bad++;
            $display("FAIL ovf_ch1_word got v=%b ch=%b q=%h ovf=%b exp v=1 ch=1 q=9 ovf=10", qv_fp, qch_fp, q_fp, ovf_fp);
        end
        tick;
        total++;
        if (qv_fp !== 1'b0) begin
            bad++;
            $display("FAIL ovf_no_extra got qv=%b exp=0", qv_fp);
        end
        clr_ovf = 1'b1;
        tick;
        clr_ovf = 1'b0;
        total++;
        if (ovf_fp !== 2'b00) begin
            bad++;
            $display("FAIL ovf_clear got=%b exp=00", ovf_fp);
        end
        tick;
        total++;
        if (ovf_fp !== 2'b00) begin
            bad++;
            $display("FAIL ovf_clear_hold got=%b exp=00", ovf_fp);
        end
    endtask

    task automatic test_collision;
        do_reset(2'b00);
        d = {4'h0, 4'h1};
        f = 2'b01;
        tick;
        d = {4'h0, 4'h2};
        f = 2'b00;
        tick;
        total++;
        if ({qv_rr, qch_rr, q_rr} !== {1'b1, 1'b0, 4'h1}) begin
            bad++;
            $display("FAIL coll_first got=%h exp=%h", {qv_rr, qch_rr, q_rr}, {1'b1, 1'b0, 4'h1});
        end
        tick;
        total++;
        if ({qv_rr, qch_rr, q_rr, ovf_rr} !== {1'b1, 1'b0, 4'h2, 2'b00}) begin
            bad++;
            $display("FAIL coll_second got v=%b ch=%b q=%h ovf=%b exp v=1 ch=0 q=2 ovf=00", qv_rr, qch_rr, q_rr, ovf_rr);
        end
        tick;
        total++;
        if (qv_rr !== 1'b0) begin
            bad++;
            $display("FAIL coll_idle got qv=%b exp=0", qv_rr);
        end
    endtask

    task automatic test_reset_mid;
        do_reset(2'b00);
        d = 8'hC3;
        f = 2'b11;
        tick;
        tick;
        total++;
        if ({qv_rr, q_rr} !== {1'b1, 4'h3}) begin
            bad++;
            $display("FAIL mid_pre got v=%b q=%h exp v=1 q=3", qv_rr, q_rr);
        end
        #2;
        rstN = 1'b0;
        #1;
        total++;
        if ({qv_rr, qch_rr, q_rr, ovf_rr} !== 8'h00) begin
            bad++;
            $display("FAIL mid_async got=%h exp=00", {qv_rr, qch_rr, q_rr, ovf_rr});
        end
        #2;
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if ({qv_rr, qch_rr, q_rr} !== 6'h00) begin
                bad++;
                $display("FAIL mid_after cyc=%0d got=%h exp=00", i, {qv_rr, qch_rr, q_rr});
            end
        end
    endtask

    // Run all scenarios in sequence and print the summary.
    initial begin
        total   = 0;
        bad     = 0;
        rstN    = 1'b0;
        f       = 2'b00;
        d       = 8'h00;
        clr_ovf = 1'b0;
        #1;
        test_reset;
        test_single;
        test_simultaneous;
        test_overflow;
        test_collision;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
